gearbox_rx_block_lock: RTL and testbench



---
 rtl/gearbox_pkg.sv | 35 +++
 rtl/gearbox_rx_block_lock_sh_window_counter.sv | 45 ++++
 rtl/gearbox_rx_block_lock.sv | 127 ++++++++++++
 tb/tb_gearbox_rx_block_lock.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gearbox_pkg.sv
// Shared constants and types for the 67-bit RX gearbox block-lock path.
// Latency: n/a (declarations only).
// Backpressure: n/a (no flow control in this package).
package gearbox_pkg;

    localparam int WORD_W     = 67;
    localparam int SH_INV_BIT = 66;
    localparam int SH_HI_BIT  = 65;
    localparam int SH_LO_BIT  = 64;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_HOLDOFF = 2'd1,
        ST_LOCKED  = 2'd2
    } lock_state_t;

    localparam int DEF_GOOD_CNT     = 64;
    localparam int DEF_WINDOW       = 64;
    localparam int DEF_BAD_MAX      = 16;
    localparam int DEF_SLIP_HOLDOFF = 4;

    // Counter width large enough to hold the larger of two limits.
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

    // A framing header is valid only when its two bits differ.
    function automatic logic sh_valid(input logic [1:0] sh);
        return sh[1] ^ sh[0];
    endfunction

endpackage

// File: rtl/gearbox_rx_block_lock_sh_window_counter.sv
// Windowed sync-header counter: consecutive-good, window position and bad count.
// Latency: flags are combinational on the current word; counts update on the next edge.
// Backpressure: none; counts only on vld cycles, holds otherwise, clr wins over counting.
module sh_window_counter #(
    parameter int GOOD_CNT = 64,
    parameter int WINDOW   = 64,
    parameter int BAD_MAX  = 16,
    parameter int CW       = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    input  logic sh_ok,
    input  logic clr,
    output logic good_done,
    output logic window_done,
    output logic bad_limit
);

    logic [CW-1:0] good_cnt;
    logic [CW-1:0] win_cnt;
    logic [CW-1:0] bad_cnt;

    // Limit flags fire on the word that would make a counter reach its limit.
    always_comb begin
        good_done   = vld & sh_ok & (good_cnt == CW'(GOOD_CNT - 1));
        window_done = vld & (win_cnt == CW'(WINDOW - 1));
        bad_limit   = vld & ~sh_ok & (bad_cnt == CW'(BAD_MAX - 1));
    end

    // Each counter clears on reaching its limit so it can never wrap.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            good_cnt <= '0;
            win_cnt  <= '0;
            bad_cnt  <= '0;
        end else if (vld) begin
            good_cnt <= (!sh_ok || good_done) ? '0 : good_cnt + CW'(1);
            win_cnt  <= window_done ? '0 : win_cnt + CW'(1);
            bad_cnt  <= (window_done || bad_limit) ? '0
                      : bad_cnt + {{(CW-1){1'b0}}, ~sh_ok};
        end
    end

endmodule

// File: rtl/gearbox_rx_block_lock.sv
// Block-lock FSM (HUNT/HOLDOFF/LOCKED) over gearbox words, issuing SLIP on misalignment.
// Latency: SLIP, BLOCK_LOCK and LOCK_STATE are registered, one cycle after the qualifying word.
// Backpressure: none; idle (DATA_IN_VALID=0) cycles freeze state. Optional BLOCK_LOCK_STATS_EN adds counters.
module gearbox_rx_block_lock
    import gearbox_pkg::*;
#(
    parameter int GOOD_CNT     = DEF_GOOD_CNT,
    parameter int WINDOW       = DEF_WINDOW,
    parameter int BAD_MAX      = DEF_BAD_MAX,
    parameter int SLIP_HOLDOFF = DEF_SLIP_HOLDOFF
) (
    input  logic              USER_CLK,
    input  logic              SYSTEM_RESET,
    input  logic [WORD_W-1:0] DATA_IN,
    input  logic              DATA_IN_VALID,
    output logic              SLIP,
    output logic              BLOCK_LOCK,
    output logic [1:0]        LOCK_STATE
`ifdef BLOCK_LOCK_STATS_EN
    ,
    output logic [7:0]        SLIP_COUNT,
    output logic [7:0]        LOCK_LOSS_COUNT
`endif
);

    localparam int CW = cnt_width(GOOD_CNT, WINDOW);
    localparam int HW = $clog2(SLIP_HOLDOFF + 1);

    lock_state_t   state;
    lock_state_t   state_nxt;
    logic          sh_ok;
    logic          good_done;
    logic          window_done;
    logic          bad_limit;
    logic          cnt_clr;
    logic          slip_nxt;
    logic          lock_nxt;
    logic          ho_done;
    logic [HW-1:0] ho_cnt;
    logic          unused_bits;

    assign sh_ok       = sh_valid(DATA_IN[SH_HI_BIT:SH_LO_BIT]);
    assign unused_bits = ^{DATA_IN[SH_INV_BIT], DATA_IN[SH_LO_BIT-1:0], window_done};
    assign LOCK_STATE  = state;

    sh_window_counter #(
        .GOOD_CNT (GOOD_CNT),
        .WINDOW   (WINDOW),
        .BAD_MAX  (BAD_MAX),
        .CW       (CW)
    ) u_cnt (
        .clk         (USER_CLK),
        .rst         (SYSTEM_RESET),
        .vld         (DATA_IN_VALID),
        .sh_ok       (sh_ok),
        .clr         (cnt_clr),
        .good_done   (good_done),
        .window_done (window_done),
        .bad_limit   (bad_limit)
    );

    // State register plus the registered SLIP/BLOCK_LOCK outputs.
    always_ff @(posedge USER_CLK) begin
        if (SYSTEM_RESET) begin
            state      <= ST_HUNT;
            SLIP       <= 1'b0;
            BLOCK_LOCK <= 1'b0;
        end else begin
            state      <= state_nxt;
            SLIP       <= slip_nxt;
            BLOCK_LOCK <= lock_nxt;
        end
    end

    // Next-state: every transition is qualified by a valid word; loss of lock beats window rollover.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_HUNT: begin
                if (DATA_IN_VALID && !sh_ok) state_nxt = ST_HOLDOFF;
                else if (good_done)          state_nxt = ST_LOCKED;
            end
            ST_HOLDOFF: begin
                if (ho_done) state_nxt = ST_HUNT;
            end
            ST_LOCKED: begin
                if (bad_limit) state_nxt = ST_HOLDOFF;
            end
            default: state_nxt = ST_HUNT;
        endcase
    end

    // Output decode: slip request, lock level, counter clear and holdoff completion.
    always_comb begin
        slip_nxt = ((state == ST_HUNT) && DATA_IN_VALID && !sh_ok)
                 || ((state == ST_LOCKED) && bad_limit);
        lock_nxt = (state_nxt == ST_LOCKED);
        cnt_clr  = (state_nxt != state) || (state == ST_HOLDOFF);
        ho_done  = (state == ST_HOLDOFF) && DATA_IN_VALID
                 && (ho_cnt == HW'(SLIP_HOLDOFF - 1));
    end

    // Holdoff counter: counts valid words while the gearbox pipeline flushes.
    always_ff @(posedge USER_CLK) begin
        if (SYSTEM_RESET) begin
            ho_cnt <= '0;
        end else if ((state == ST_HOLDOFF) && DATA_IN_VALID) begin
            ho_cnt <= ho_done ? '0 : ho_cnt + HW'(1);
        end
    end

`ifdef BLOCK_LOCK_STATS_EN
    // Saturating event counters for slip pulses and lock losses.
    always_ff @(posedge USER_CLK) begin
        if (SYSTEM_RESET) begin
            SLIP_COUNT      <= 8'd0;
            LOCK_LOSS_COUNT <= 8'd0;
        end else begin
            if (slip_nxt && (SLIP_COUNT != 8'hFF))
                SLIP_COUNT <= SLIP_COUNT + 8'd1;
            if ((state == ST_LOCKED) && (state_nxt == ST_HOLDOFF) && (LOCK_LOSS_COUNT != 8'hFF))
                LOCK_LOSS_COUNT <= LOCK_LOSS_COUNT + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gearbox_rx_block_lock.sv
// Self-checking bench for gearbox_rx_block_lock: vector table, directed sequences, random vs model.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: none; DATA_IN_VALID randomly idles the stream.
module tb_gearbox_rx_block_lock;

    localparam int GOOD = 64;
    localparam int WIN  = 64;
    localparam int BADM = 16;
    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [66:0] din;
    logic        dv;
    logic        slip;
    logic        blk;
    logic [1:0]  lst;
`ifdef BLOCK_LOCK_STATS_EN
    logic [7:0]  slip_count;
    logic [7:0]  loss_count;
`endif

    always #5 clk = ~clk;

    gearbox_rx_block_lock dut (
        .USER_CLK        (clk),
        .SYSTEM_RESET    (rst),
        .DATA_IN         (din),
        .DATA_IN_VALID   (dv),
        .SLIP            (slip),
        .BLOCK_LOCK      (blk),
        .LOCK_STATE      (lst)
`ifdef BLOCK_LOCK_STATS_EN
        ,
        .SLIP_COUNT      (slip_count),
        .LOCK_LOSS_COUNT (loss_count)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int slip_seen = 0;

    // Behavioural model: mode 0=hunt,1=holdoff,2=locked, plain integer bookkeeping.
    int m_state = 0;
    int m_run   = 0;   // consecutive good headers while hunting
    int m_hold  = 0;   // valid words consumed during holdoff
    int m_pos   = 0;   // words seen in the current lock window
    int m_bad   = 0;   // bad words seen in the current lock window
    int m_slip  = 0;
    int m_lock  = 0;
    int m_slips = 0;
    int m_loss  = 0;

    function automatic void model_step(input bit r, input bit v, input bit [1:0] h);
        bit ok;
        m_slip = 0;
        if (r) begin
            m_state = 0; m_run = 0; m_hold = 0; m_pos = 0; m_bad = 0;
            m_lock = 0; m_slips = 0; m_loss = 0;
            return;
        end
        if (!v) return;
        ok = (h == 2'b01) || (h == 2'b10);
        if (m_state == 0) begin
            if (!ok) begin
                m_slip = 1; m_run = 0; m_hold = 0; m_state = 1;
            end else begin
                m_run++;
                if (m_run == GOOD) begin
                    m_state = 2; m_lock = 1; m_run = 0; m_pos = 0; m_bad = 0;
                end
            end
        end else if (m_state == 1) begin
            m_hold++;
            if (m_hold == HOLD) begin
                m_state = 0; m_hold = 0; m_run = 0;
            end
        end else begin
            m_pos++;
            if (!ok) m_bad++;
            if (m_bad == BADM) begin
                m_lock = 0; m_slip = 1; m_state = 1; m_hold = 0;
                m_pos = 0; m_bad = 0; m_loss = (m_loss < 255) ? m_loss + 1 : 255;
            end else if (m_pos == WIN) begin
                m_pos = 0; m_bad = 0;
            end
        end
        if (m_slip == 1) m_slips = (m_slips < 255) ? m_slips + 1 : 255;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, advance the model, sample 1 ns after the edge.
    task automatic cycle(input bit r, input bit v, input bit [1:0] h);
        @(negedge clk);
        rst = r;
        dv  = v;
        din = {1'($urandom), h, $urandom, $urandom};
        model_step(r, v, h);
        @(posedge clk);
        #1;
        slip_seen += int'(slip);
        chk("slip", int'(slip), m_slip);
        chk("block_lock", int'(blk), m_lock);
        chk("lock_state", int'(lst), m_state);
`ifdef BLOCK_LOCK_STATS_EN
        chk("slip_count", int'(slip_count), m_slips);
        chk("lock_loss_count", int'(loss_count), m_loss);
`endif
    endtask

    task automatic send_good(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, (i % 2) ? 2'b10 : 2'b01);
    endtask

    typedef struct {
        bit       r;
        bit       v;
        bit [1:0] h;
        int       e_slip;
        int       e_lock;
        int       e_state;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit r, input bit v, input bit [1:0] h,
                                input int es, input int el, input int st);
        vec_t x;
        x.r = r; x.v = v; x.h = h; x.e_slip = es; x.e_lock = el; x.e_state = st;
        return x;
    endfunction

    initial begin
        // Hunt, slip on 10th word, holdoff ignores 4 bad headers and an idle cycle.
        tbl.push_back(mk(1, 0, 2'b00, 0, 0, 0));
        for (int i = 0; i < 9; i++) tbl.push_back(mk(0, 1, 2'b01, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b00, 1, 0, 1));
        tbl.push_back(mk(0, 0, 2'b00, 0, 0, 1));
        tbl.push_back(mk(0, 1, 2'b11, 0, 0, 1));
        tbl.push_back(mk(0, 1, 2'b11, 0, 0, 1));
        tbl.push_back(mk(0, 1, 2'b11, 0, 0, 1));
        tbl.push_back(mk(0, 1, 2'b11, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b10, 0, 0, 0));

        rst = 1'b1; dv = 1'b0; din = '0;
        cycle(1'b1, 1'b0, 2'b00);
        cycle(1'b1, 1'b0, 2'b00);
        chk("reset_slip", int'(slip), 0);
        chk("reset_lock", int'(blk), 0);
        chk("reset_state", int'(lst), 0);

        // 1: alternating headers with idle gaps, lock after the 64th word.
        cycle(1'b0, 1'b0, 2'b00);
        slip_seen = 0;
        for (int i = 0; i < GOOD; i++) begin
            cycle(1'b0, 1'b1, (i % 2) ? 2'b10 : 2'b01);
            if (i == GOOD - 2) chk("t1_no_lock_at_63", int'(blk), 0);
            if (i == GOOD - 1) begin
                chk("t1_lock_at_64", int'(blk), 1);
                chk("t1_state_locked", int'(lst), 2);
            end
            cycle(1'b0, 1'b0, 2'b00);
        end
        chk("t1_no_slip", slip_seen, 0);

        // 2: table-driven slip and holdoff, then 64 fresh words to relock.
        foreach (tbl[k]) begin
            cycle(tbl[k].r, tbl[k].v, tbl[k].h);
            chk($sformatf("t2_vec%0d_slip", k), int'(slip), tbl[k].e_slip);
            chk($sformatf("t2_vec%0d_lock", k), int'(blk), tbl[k].e_lock);
            chk($sformatf("t2_vec%0d_state", k), int'(lst), tbl[k].e_state);
        end
        send_good(GOOD - 2);
        chk("t2_no_lock_at_63", int'(blk), 0);
        send_good(1);
        chk("t2_relock_at_64", int'(blk), 1);

        // 3: 15 bad in a window keeps lock; 16 bad loses it with SLIP on the same edge.
        for (int i = 0; i < WIN; i++)
            cycle(1'b0, 1'b1, ((i % 4) == 0 && i < 60) ? 2'b11 : 2'b01);
        chk("t3_15bad_lock", int'(blk), 1);
        for (int i = 0; i < 31; i++) begin
            cycle(1'b0, 1'b1, ((i % 2) == 0) ? 2'b11 : 2'b10);
            if (i == 28) chk("t3_15th_bad_lock", int'(blk), 1);
            if (i == 30) begin
                chk("t3_16bad_slip", int'(slip), 1);
                chk("t3_16bad_lock", int'(blk), 0);
                chk("t3_16bad_state", int'(lst), 1);
            end
        end

        // 4: 10 bad at end of one window and 10 at the start of the next keep lock.
        send_good(HOLD + GOOD);
        chk("t4_locked", int'(blk), 1);
        for (int i = 0; i < WIN; i++) cycle(1'b0, 1'b1, (i >= 54) ? 2'b00 : 2'b01);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 2'b11);
        send_good(20);
        chk("t4_lock_held", int'(blk), 1);
        chk("t4_state", int'(lst), 2);

        // 5: reset during the SLIP cycle and during holdoff.
        cycle(1'b1, 1'b0, 2'b00);
        send_good(5);
        cycle(1'b0, 1'b1, 2'b00);
        chk("t5_slip_pulse", int'(slip), 1);
        cycle(1'b1, 1'b1, 2'b00);
        chk("t5_rst_slip", int'(slip), 0);
        chk("t5_rst_lock", int'(blk), 0);
        chk("t5_rst_state", int'(lst), 0);
        cycle(1'b0, 1'b1, 2'b11);
        cycle(1'b0, 1'b1, 2'b01);
        chk("t5_in_holdoff", int'(lst), 1);
        cycle(1'b1, 1'b1, 2'b01);
        chk("t5_rst2_slip", int'(slip), 0);
        chk("t5_rst2_state", int'(lst), 0);
        send_good(GOOD - 1);
        chk("t5_no_lock_63", int'(blk), 0);
        send_good(1);
        chk("t5_lock_64", int'(blk), 1);

        // Random traffic with varying bad-header density, checked against the model.
        for (int p = 0; p < 24; p++) begin
            int rate;
            case ($urandom_range(0, 4))
                0: rate = 0;
                1: rate = 0;
                2: rate = 5;
                3: rate = 30;
                default: rate = 300;
            endcase
            for (int c = 0; c < 150; c++) begin
                bit v;
                bit [1:0] h;
                v = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 999) < rate)
                    h = $urandom_range(0, 1) ? 2'b00 : 2'b11;
                else
                    h = $urandom_range(0, 1) ? 2'b01 : 2'b10;
                cycle(($urandom_range(0, 499) == 0), v, h);
            end
        end

`ifdef BLOCK_LOCK_STATS_EN
        // 6: three hunt slips, one lock loss, then saturation of the slip counter.
        cycle(1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            send_good(HOLD);
            cycle(1'b0, 1'b1, 2'b00);
        end
        send_good(HOLD + GOOD);
        for (int i = 0; i < BADM; i++) cycle(1'b0, 1'b1, 2'b11);
        chk("t6_slip_count_4", int'(slip_count), 4);
        chk("t6_loss_count_1", int'(loss_count), 1);
        for (int i = 0; i < 300; i++) begin
            send_good(HOLD);
            cycle(1'b0, 1'b1, 2'b00);
        end
        chk("t6_slip_count_sat", int'(slip_count), 255);
        chk("t6_loss_count_held", int'(loss_count), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
